arb_grant_pipe: RTL
===================

ARB_GRANT_PIPE -- requirements
Module: arb_grant_pipe

Interface
REQ-001 Parameter N, default 4, number of requesters, legal range 2..32.
REQ-002 Parameter DATA_WIDTH, default 8, payload bits per requester, legal range 1..256.
REQ-003 Parameter IDX_WIDTH, default 2, bits of out_index, SHALL equal ceil(log2(N)).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 init_n  input  1  synchronous active-low init; same effect as reset, applied on the clk edge.
REQ-008 granted  input  1  round-robin arbiter reports a grant this cycle.
REQ-009 grant  input  N  one-hot grant vector from the arbiter.
REQ-010 data_in  input  N*DATA_WIDTH  requester payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 arb_enable  output  1  drives the arbiter enable; high when the buffer can accept.
REQ-012 ack  output  N  one-cycle pulse to the requester whose payload was captured.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  consumer accepts the head entry.
REQ-015 out_data  output  DATA_WIDTH  head payload.
REQ-016 out_index  output  IDX_WIDTH  binary index of the requester that produced the head payload.
REQ-017 grant_err  output  1  sticky flag: a malformed grant was seen.

Function
REQ-018 Storage SHALL be a 2-entry FIFO of {index, data} with a registered occupancy count in 0..2.
REQ-019 arb_enable SHALL be 1 when count<2, is registered or derived only from count, and has no combinational path from out_ready.
REQ-020 push SHALL be granted & arb_enable & (grant is exactly one-hot).
REQ-021 On push, the FIFO SHALL capture data_in slice i and index i, where i is the set bit of grant.
REQ-022 ack[i] SHALL be high during the cycle after the push edge; all other ack bits SHALL be 0, and ack SHALL never have more than one bit set.
REQ-023 pop SHALL be out_valid & out_ready; out_valid SHALL equal (count>0).
REQ-024 out_data and out_index SHALL show the oldest entry and stay stable while out_valid=1 and out_ready=0.
REQ-025 Latency SHALL be one cycle: push at edge t makes out_valid=1 with the new data after edge t when the FIFO was empty.
REQ-026 Simultaneous push and pop at count=1 SHALL keep count=1; the new entry becomes the head after the edge.
REQ-027 At count=2, arb_enable=0, so no push can occur even when pop is high that cycle; count SHALL become 1.
REQ-028 A pop at count=0 SHALL be impossible, since out_valid=0.
REQ-029 granted=1 with grant zero or multi-hot SHALL cause no push and no ack, and SHALL set grant_err to 1 until reset or init.
REQ-030 granted=1 while arb_enable=0 SHALL be ignored, with no push, no ack and no error.
REQ-031 FIFO pointers SHALL wrap modulo 2.

Reset
REQ-032 On rst_n=0, asynchronously: count=0, pointers=0, out_valid=0, ack=0, grant_err=0, arb_enable=1.
REQ-033 out_data and out_index SHALL read 0 after reset.
REQ-034 init_n=0 SHALL apply the REQ-032 values at the next edge and take priority over a push or pop in the same cycle.
REQ-035 Reset or init while entries are pending SHALL discard them without issuing further acks.

Verification
REQ-036 N=4, DATA_WIDTH=8, data_in={0x44,0x33,0x22,0x11}, grant=0100, granted=1, out_ready=1 -> next cycle out_valid=1, out_data=0x33, out_index=2, ack=0100.
REQ-037 out_ready=0 with three consecutive grants 0001, 0010, 1000 -> first two captured, arb_enable=0 from then on, third gets no ack; out_data stays 0x11 until out_ready=1.
REQ-038 count=1 with push of grant=1000 and pop in the same cycle -> count stays 1, the head becomes index 3 with data 0x44.
REQ-039 granted=1 with grant=0110 -> no ack, count unchanged, grant_err=1 and it stays 1 across later valid grants.
REQ-040 count=2, then rst_n asserted mid-cycle -> out_valid, ack and grant_err drop to 0 immediately, and arb_enable=1.
REQ-041 init_n=0 together with a valid grant -> no push and no ack, and count=0 after the edge.

Source files
------------

// File: rtl/arb_grant_pipe_if.sv
// Arbiter-grant capture bus: grant/payload in, 2-deep buffered head out.
// Carries the arbiter enable, per-requester acks and the error flag.
interface arb_grant_pipe_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
);
  logic                    granted;
  logic [N-1:0]            grant;
  logic [N*DATA_WIDTH-1:0] data_in;
  logic                    arb_enable;
  logic [N-1:0]            ack;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [IDX_WIDTH-1:0]    out_index;
  logic                    grant_err;

  modport master (
    output granted, grant, data_in, out_ready,
    input  arb_enable, ack, out_valid,
    input  out_data, out_index, grant_err
  );

  modport slave (
    input  granted, grant, data_in, out_ready,
    output arb_enable, ack, out_valid,
    output out_data, out_index, grant_err
  );
endinterface

// File: rtl/arb_grant_pipe.sv
// Captures the granted requester's payload into a 2-entry FIFO,
// pulses ack back to it, and flags malformed grant vectors.
module arb_grant_pipe #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init_n,
  arb_grant_pipe_if.slave bus
);

  logic [1:0]            count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [2];
  logic [IDX_WIDTH-1:0]  mem_idx  [2];
  logic [N-1:0]          ack_q;
  logic                  err_q;

  logic                  one_hot;
  logic                  push;
  logic                  pop;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;

  assign one_hot = (bus.grant != '0) &&
                   ((bus.grant & (bus.grant - 1'b1)) == '0);

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.grant[i]) begin
        sel_idx  = IDX_WIDTH'(i);
        sel_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Enable depends on registered count only, never on out_ready.
  assign bus.arb_enable = (count != 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign push = bus.granted & bus.arb_enable & one_hot;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_index = mem_idx[rd_ptr];
  assign bus.ack       = ack_q;
  assign bus.grant_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_idx[0]  <= '0;
      mem_idx[1]  <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else if (!init_n) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_idx[0]  <= '0;
      mem_idx[1]  <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= push ? bus.grant : '0;
      if (bus.granted && bus.arb_enable && !one_hot)
        err_q <= 1'b1;
      if (push) begin
        mem_data[wr_ptr] <= sel_data;
        mem_idx[wr_ptr]  <= sel_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case (1'b1)
        push && !pop: count <= count + 2'd1;
        pop && !push: count <= count - 2'd1;
        default:      count <= count;
      endcase
    end
  end

endmodule
